// File: rtl/wb_async_mem_sync_pkg.sv
// Shared constants and helpers for the async-memory input conditioning stage.
// Idle pin levels, counter width and a saturating increment used by every counter.
package wb_async_mem_sync_pkg;

  localparam logic MEM_CTRL_IDLE = 1'b1;
  localparam logic MEM_DATA_IDLE = 1'b0;
  localparam int   CNT_W         = 4;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic oe_n;
    logic we_n;
    logic cs_n;
  } mem_ctrl_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val,
                                               input logic [CNT_W-1:0] lim);
    return (val >= lim) ? lim : val + 1'b1;
  endfunction

endpackage

// File: rtl/wb_async_mem_sync_chain.sv
// Multi-flop synchronizer for one pin group; reset loads the group's idle level.
// Bits of a multi-bit group may resolve on different cycles.
module wb_async_mem_sync_chain #(
  parameter int               WIDTH   = 1,
  parameter int               STAGES  = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] stage;

  // NOTE: synchronizer flops are plain registers (no memory inference), so resetting them is cheap and required.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      stage <= {STAGES{RST_VAL}};
    end else begin
      stage <= {stage[STAGES-2:0], d};
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/wb_async_mem_sync.sv
// Input conditioning for the async memory bridge: synchronizes all pins, derives
// strobe edge pulses, a bus-stability qualifier and a short-pulse (glitch) flag.
module wb_async_mem_sync
  import wb_async_mem_sync_pkg::*;
#(
  parameter int DW            = 32,
  parameter int AW            = 32,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 2,
  parameter int MIN_PULSE     = 2
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic [DW-1:0] mem_d_i,
  input  logic [AW-1:0] mem_a_i,
  input  logic [3:0]    mem_bls_n_i,
  input  logic          mem_oe_n_i,
  input  logic          mem_we_n_i,
  input  logic          mem_cs_n_i,
  output logic [DW-1:0] mem_d_s,
  output logic [AW-1:0] mem_a_s,
  output logic [3:0]    mem_bls_n_s,
  output logic          mem_oe_n_s,
  output logic          mem_we_n_s,
  output logic          mem_cs_n_s,
  output logic          mem_oe_n_fall,
  output logic          mem_we_n_fall,
  output logic          mem_we_n_rise,
  output logic          mem_bus_stable,
  output logic          glitch_o
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("SYNC_STAGES must be in 2..4");
  end
  if (STABLE_CYCLES < 1 || STABLE_CYCLES > 15) begin : g_bad_stable
    $error("STABLE_CYCLES must be in 1..15");
  end
  if (MIN_PULSE < 1 || MIN_PULSE > 15) begin : g_bad_pulse
    $error("MIN_PULSE must be in 1..15");
  end

  localparam int               CMP_W    = AW + 4 + DW;
  localparam logic [CNT_W-1:0] STAB_LIM = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] MIN_LIM  = CNT_W'(MIN_PULSE);
  localparam logic [CMP_W-1:0] CMP_IDLE = {{AW{MEM_DATA_IDLE}}, {4{MEM_CTRL_IDLE}}, {DW{MEM_DATA_IDLE}}};

  mem_ctrl_t ctrl_raw, ctrl_s;

  assign ctrl_raw = '{oe_n: mem_oe_n_i, we_n: mem_we_n_i, cs_n: mem_cs_n_i};

  wb_async_mem_sync_chain #(.WIDTH(DW), .STAGES(SYNC_STAGES), .RST_VAL({DW{MEM_DATA_IDLE}})) u_sync_d (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .d(mem_d_i), .q(mem_d_s)
  );

  wb_async_mem_sync_chain #(.WIDTH(AW), .STAGES(SYNC_STAGES), .RST_VAL({AW{MEM_DATA_IDLE}})) u_sync_a (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .d(mem_a_i), .q(mem_a_s)
  );

  wb_async_mem_sync_chain #(.WIDTH(4), .STAGES(SYNC_STAGES), .RST_VAL({4{MEM_CTRL_IDLE}})) u_sync_bls (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .d(mem_bls_n_i), .q(mem_bls_n_s)
  );

  wb_async_mem_sync_chain #(.WIDTH(3), .STAGES(SYNC_STAGES), .RST_VAL({3{MEM_CTRL_IDLE}})) u_sync_ctrl (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .d(ctrl_raw), .q(ctrl_s)
  );

  assign mem_oe_n_s = ctrl_s.oe_n;
  assign mem_we_n_s = ctrl_s.we_n;
  assign mem_cs_n_s = ctrl_s.cs_n;

  // Edge detection against a one-cycle history of each synchronized strobe.
  logic oe_hist, we_hist;
  logic oe_fell, we_fell, oe_rose, we_rose;

  assign oe_fell = oe_hist & ~mem_oe_n_s;
  assign we_fell = we_hist & ~mem_we_n_s;
  assign oe_rose = ~oe_hist & mem_oe_n_s;
  assign we_rose = ~we_hist & mem_we_n_s;

  assign mem_oe_n_fall = oe_fell & ~mem_cs_n_s;
  assign mem_we_n_fall = we_fell & ~mem_cs_n_s;
  assign mem_we_n_rise = we_rose;

  logic [CMP_W-1:0] cmp, cmp_prev;
  logic [CNT_W-1:0] stab_cnt, stab_cnt_next;
  logic [CNT_W-1:0] oe_low_cnt, we_low_cnt;

  // NOTE: every signal written in always_comb gets a default first, so no latch can be inferred.
  always_comb begin
    cmp           = {mem_a_s, mem_bls_n_s, mem_we_n_s ? {DW{1'b0}} : mem_d_s};
    stab_cnt_next = sat_inc(stab_cnt, STAB_LIM);
    if (mem_cs_n_s || (cmp != cmp_prev)) begin
      stab_cnt_next = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      oe_hist        <= MEM_CTRL_IDLE;
      we_hist        <= MEM_CTRL_IDLE;
      cmp_prev       <= CMP_IDLE;
      stab_cnt       <= '0;
      mem_bus_stable <= 1'b0;
      oe_low_cnt     <= '0;
      we_low_cnt     <= '0;
    end else begin
      oe_hist        <= mem_oe_n_s;
      we_hist        <= mem_we_n_s;
      cmp_prev       <= cmp;
      stab_cnt       <= stab_cnt_next;
      mem_bus_stable <= (stab_cnt_next == STAB_LIM);

      // The fall cycle is itself the first low cycle, so the count restarts at 1.
      if (oe_fell)          oe_low_cnt <= CNT_W'(1);
      else if (!mem_oe_n_s) oe_low_cnt <= sat_inc(oe_low_cnt, CNT_MAX);

      if (we_fell)          we_low_cnt <= CNT_W'(1);
      else if (!mem_we_n_s) we_low_cnt <= sat_inc(we_low_cnt, CNT_MAX);
    end
  end

  assign glitch_o = (oe_rose && (oe_low_cnt < MIN_LIM)) ||
                    (we_rose && (we_low_cnt < MIN_LIM));

endmodule

// File: tb/tb_wb_async_mem_sync.sv
// Randomized self-checking bench for wb_async_mem_sync against a pin-history reference model.
// Synchronized values are read from the recorded pin history SYNC_STAGES-1 cycles back.
module tb_wb_async_mem_sync;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int SS    = 2;
  localparam int STAB  = 2;
  localparam int MINP  = 2;
  localparam int DEPTH = 4096;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [AW-1:0] a;
    logic [3:0]    bls;
    logic          oe;
    logic          we;
    logic          cs;
  } pins_t;

  localparam pins_t IDLE = '{d: '0, a: '0, bls: 4'hF, oe: 1'b1, we: 1'b1, cs: 1'b1};

  logic          wb_clk_i, wb_rst_i;
  logic [DW-1:0] mem_d_i, mem_d_s;
  logic [AW-1:0] mem_a_i, mem_a_s;
  logic [3:0]    mem_bls_n_i, mem_bls_n_s;
  logic          mem_oe_n_i, mem_we_n_i, mem_cs_n_i;
  logic          mem_oe_n_s, mem_we_n_s, mem_cs_n_s;
  logic          mem_oe_n_fall, mem_we_n_fall, mem_we_n_rise, mem_bus_stable, glitch_o;

  wb_async_mem_sync #(
    .DW(DW), .AW(AW), .SYNC_STAGES(SS), .STABLE_CYCLES(STAB), .MIN_PULSE(MINP)
  ) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .mem_d_i(mem_d_i), .mem_a_i(mem_a_i), .mem_bls_n_i(mem_bls_n_i),
    .mem_oe_n_i(mem_oe_n_i), .mem_we_n_i(mem_we_n_i), .mem_cs_n_i(mem_cs_n_i),
    .mem_d_s(mem_d_s), .mem_a_s(mem_a_s), .mem_bls_n_s(mem_bls_n_s),
    .mem_oe_n_s(mem_oe_n_s), .mem_we_n_s(mem_we_n_s), .mem_cs_n_s(mem_cs_n_s),
    .mem_oe_n_fall(mem_oe_n_fall), .mem_we_n_fall(mem_we_n_fall),
    .mem_we_n_rise(mem_we_n_rise), .mem_bus_stable(mem_bus_stable), .glitch_o(glitch_o)
  );

  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  pins_t hist [DEPTH];
  int    cyc;
  int    n_cmp;
  int    n_err;
  int    we_fall_seen;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  // Value visible on the *_s outputs after clock edge k (edge 1 is the first after reset release).
  function automatic pins_t syn(input int k);
    int idx;
    idx = k - SS + 1;
    if (idx < 1) return IDLE;
    return hist[idx];
  endfunction

  function automatic logic [AW+4+DW-1:0] cmp_of(input int k);
    pins_t s;
    s = syn(k);
    return {s.a, s.bls, s.we ? {DW{1'b0}} : s.d};
  endfunction

  // Stable after edge k when the previous STAB cycles all had cs low and no bus change.
  function automatic logic exp_stable(input int k);
    pins_t s;
    for (int j = k - STAB; j < k; j++) begin
      s = syn(j);
      if (j < 1 || s.cs || (cmp_of(j) != cmp_of(j - 1))) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Length of the low run of a strobe ending just before edge k.
  function automatic int low_run(input int k, input bit is_we);
    pins_t s;
    int    n;
    int    j;
    n = 0;
    j = k - 1;
    while (j >= 1) begin
      s = syn(j);
      if ((is_we ? s.we : s.oe) != 1'b0) break;
      n++;
      j--;
    end
    return n;
  endfunction

  task automatic check_all();
    pins_t s, sp;
    logic  e_glitch;
    s  = syn(cyc);
    sp = syn(cyc - 1);
    e_glitch = (~sp.oe & s.oe & (low_run(cyc, 1'b0) < MINP)) |
               (~sp.we & s.we & (low_run(cyc, 1'b1) < MINP));
    check("d_s",     64'(mem_d_s),        64'(s.d));
    check("a_s",     64'(mem_a_s),        64'(s.a));
    check("bls_n_s", 64'(mem_bls_n_s),    64'(s.bls));
    check("oe_n_s",  64'(mem_oe_n_s),     64'(s.oe));
    check("we_n_s",  64'(mem_we_n_s),     64'(s.we));
    check("cs_n_s",  64'(mem_cs_n_s),     64'(s.cs));
    check("oe_fall", 64'(mem_oe_n_fall),  64'(sp.oe & ~s.oe & ~s.cs));
    check("we_fall", 64'(mem_we_n_fall),  64'(sp.we & ~s.we & ~s.cs));
    check("we_rise", 64'(mem_we_n_rise),  64'(~sp.we & s.we));
    check("stable",  64'(mem_bus_stable), 64'(exp_stable(cyc)));
    check("glitch",  64'(glitch_o),       64'(e_glitch));
  endtask

  task automatic apply(input pins_t p);
    mem_d_i     = p.d;
    mem_a_i     = p.a;
    mem_bls_n_i = p.bls;
    mem_oe_n_i  = p.oe;
    mem_we_n_i  = p.we;
    mem_cs_n_i  = p.cs;
  endtask

  // Called at a falling edge: present pins, take one rising edge, check, return at next falling edge.
  task automatic drive(input pins_t p);
    apply(p);
    if (cyc + 1 < DEPTH) hist[cyc + 1] = p;
    @(posedge wb_clk_i);
    cyc++;
    #1;
    check_all();
    if (mem_we_n_fall) we_fall_seen++;
    @(negedge wb_clk_i);
  endtask

  task automatic drive_n(input pins_t p, input int n);
    for (int i = 0; i < n; i++) drive(p);
  endtask

  pins_t p;

  initial begin
    #1_000_000;
    $display("FAIL timeout cyc=%0d observed=running expected=finished", cyc);
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    cyc   = 0;
    we_fall_seen = 0;

    // Idle reset, then ten idle cycles with no pulses.
    wb_rst_i = 1'b1;
    apply(IDLE);
    repeat (3) @(negedge wb_clk_i);
    check_all();
    wb_rst_i = 1'b0;
    drive_n(IDLE, 10);

    // Steady access at 0x100, then write strobe drops.
    p = IDLE; p.cs = 1'b0; p.a = 32'h100; p.bls = 4'h0;
    drive_n(p, 4);
    p.we = 1'b0; p.d = 32'hA5A5_0001;
    drive_n(p, 6);

    // Address change while stable.
    p.a = 32'h104;
    drive_n(p, 6);
    p.we = 1'b1;
    drive_n(p, 4);

    // Read strobe pulses of 1, 2 and 3 cycles.
    for (int w = 1; w <= 3; w++) begin
      p.oe = 1'b0; drive_n(p, w);
      p.oe = 1'b1; drive_n(p, 4);
    end

    // Both strobes fall together.
    p.oe = 1'b0; p.we = 1'b0;
    drive_n(p, 3);
    p.oe = 1'b1; p.we = 1'b1;
    drive_n(p, 3);

    // Asynchronous reset in the middle of a write.
    p.we = 1'b0; p.d = 32'h1234_5678;
    drive_n(p, 4);
    #2;
    wb_rst_i = 1'b1;
    #1;
    cyc = 0;
    check_all();
    repeat (2) @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    we_fall_seen = 0;
    drive_n(p, 6);
    check("we_fall_count_after_reset", 64'(we_fall_seen), 64'd1);
    p.we = 1'b1;
    drive_n(p, 3);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(7) == 0)  p.a   = 32'h100 + 32'($urandom_range(3)) * 4;
      if ($urandom_range(3) == 0)  p.d   = $urandom;
      if ($urandom_range(7) == 0)  p.bls = 4'($urandom_range(15));
      if ($urandom_range(2) == 0)  p.oe  = ~p.oe;
      if ($urandom_range(2) == 0)  p.we  = ~p.we;
      if ($urandom_range(15) == 0) p.cs  = ~p.cs;
      drive(p);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
